sevenseg_scan_ctrl: RTL and testbench
=====================================

# sevenseg_scan_ctrl

Scan and conversion controller for the three-digit seven-segment display. It converts the 8-bit DIP-switch value to hex nibbles or decimal BCD digits; decimal conversion is a sequential double-dabble FSM. It then time-multiplexes one shared nibble/segment decoder across three common-anode digits, with anti-ghosting blank time. It sits between the switch inputs and the existing nibble-to-segment decoder.

## Interface
- REFRESH_DIV, 12000: clock cycles per digit slot; legal range 2..65535.
- BLANK_CYCLES, 64: cycles at the start of each slot with all digits disabled; must be < REFRESH_DIV.
- LZ_SUPPRESS, 1: 1 = blank leading zeros in decimal mode.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- sw  in  8  value to display, already synchronised.
- hex_mode  in  1  1 = hex (two digits), 0 = decimal (three digits, 0..255).
- nibble  out  4  digit value to the segment decoder, registered.
- blank  out  1  1 = decoder drives all segments off.
- digit_en  out  3  one-hot digit enable, active-high; bit 0 = ones, bit 2 = hundreds.
- busy  out  1  1 while a conversion/commit is in progress.

## Operation
- Source register last_src[8:0] = {hex_mode, sw} of the last accepted input. Digit registers d2, d1, d0 hold 4 bits each, with per-digit blank flags.
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - If {hex_mode, sw} != last_src, capture the input into last_src and the work register.
  - hex_mode=1: go to COMMIT.
  - hex_mode=0: clear the BCD register (12 bits), set bit_cnt=0, go to CONV.
- CONV, one iteration per cycle:
  - Each BCD nibble >= 5 gets +3.
  - Then {bcd, work} shifts left by 1 and bit_cnt increments.
  - After the 8th iteration (bit_cnt==7), go to COMMIT.
- COMMIT:
  - Hex: d2=0 with blank2=1; d1=sw[7:4], d0=sw[3:0]; blank1=blank0=0.
  - Decimal: d2/d1/d0 = hundreds/tens/ones.
    - With LZ_SUPPRESS=1: blank2 = (d2==0); blank1 = (d2==0 && d1==0).
    - blank0 is always 0.
  - Return to IDLE.
- Input changes during CONV/COMMIT are ignored. They are re-detected in the first IDLE cycle, so the final displayed value always matches the stable input.
- busy = 1 in CONV and COMMIT.
- Scan:
  - slot_cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, digit_idx advances 0→1→2→0.
  - For slot_cnt < BLANK_CYCLES: digit_en=000.
  - Otherwise: digit_en = one-hot(digit_idx), nibble = d[digit_idx], blank = blank[digit_idx].
  - During blank time, nibble holds and blank=1.
- Committed digits take effect at the next output register update, even mid-slot. Tearing is accepted.

## Timing
- Reset values: nibble=0, blank=1, digit_en=000, busy=0, FSM=IDLE, slot_cnt=0, digit_idx=0, last_src=0, d2=d1=d0=0, blank2=blank1=1, blank0=0.
- Decimal latency: input change sampled at edge N (capture), CONV at edges N+1..N+8, COMMIT at N+9. Digit registers are valid after N+9; outputs reflect them at N+10 if the slot is active.
- Hex latency: capture at N, COMMIT at N+1, outputs at N+2.
- busy rises the cycle after capture and falls the cycle after COMMIT.
- Scan period = 3×REFRESH_DIV cycles. Each digit is enabled for REFRESH_DIV−BLANK_CYCLES cycles per period.
- Reset mid-conversion: next cycle is IDLE with reset values. If input ≠ 0, a fresh conversion starts the cycle after reset deasserts.
- Mode toggle with sw unchanged counts as a change and triggers recomputation.
- digit_en is never more than one-hot. There is always ≥1 cycle of 000 between different digits, since BLANK_CYCLES ≥ 1 is required.

## Test plan
- Reset, sw=0, hex_mode=0:
  - No conversion (busy stays 0).
  - Ones slot shows nibble=0, blank=0; tens and hundreds slots have blank=1.
- sw=8'd255, decimal:
  - busy high for exactly 9 cycles.
  - Digits 2,5,5 with none blanked; each digit_en active REFRESH_DIV−BLANK_CYCLES cycles per period.
- sw=8'd7, decimal, LZ_SUPPRESS=1:
  - d0=7; hundreds and tens blank=1.
  - Repeat with LZ_SUPPRESS=0: shows 0,0,7 unblanked.
- sw=8'hA5, hex_mode=1:
  - Commit after 2 cycles; d1=A, d0=5; hundreds blank=1.
  - Toggle to hex_mode=0: recompute gives 1,6,5.
- Change sw 100→199 at cycle 3 of a conversion:
  - First commit shows 1,0,0.
  - A second conversion starts immediately; final display 1,9,9.
- Assert rst during CONV of 8'd200:
  - All outputs return to reset values the next cycle.
  - After release, conversion restarts and displays 2,0,0.
- Small-parameter sweep (REFRESH_DIV=4, BLANK_CYCLES=1):
  - digit_en sequence 000,001,001,001,000,010,… and never two bits set.

Source files
------------

// File: rtl/sevenseg_scan_ctrl_if.sv
// rtl/sevenseg_scan_ctrl_if.sv - switch inputs and display-drive outputs of the scan controller
// Signals:
//   sw, hex_mode            value and mode presented to the controller
//   nibble, blank, digit_en drive to the shared segment decoder and digit anodes
//   busy                    conversion/commit in progress
// master: the side supplying the switches and observing the display drive.
// slave : the controller itself.
interface sevenseg_scan_ctrl_if;
    logic [7:0] sw;
    logic       hex_mode;
    logic [3:0] nibble;
    logic       blank;
    logic [2:0] digit_en;
    logic       busy;

    modport master (
        output sw,
        output hex_mode,
        input  nibble,
        input  blank,
        input  digit_en,
        input  busy
    );

    modport slave (
        input  sw,
        input  hex_mode,
        output nibble,
        output blank,
        output digit_en,
        output busy
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - switch-to-digit conversion and three-digit multiplexed scan
// Converts the 8-bit switch value to two hex digits or three BCD digits (sequential
// double-dabble), then time-multiplexes one nibble decoder across three common-anode
// digits with a blanking gap at the start of every digit slot.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  slave side of sevenseg_scan_ctrl_if (sw, hex_mode in; nibble, blank,
//        digit_en, busy out)
module sevenseg_scan_ctrl #(
    parameter int REFRESH_DIV  = 12000,
    parameter int BLANK_CYCLES = 64,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sevenseg_scan_ctrl_if.slave   bus
);

    localparam logic [15:0] SLOT_MAX = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] BLANK_W  = 16'(BLANK_CYCLES);
    localparam logic        LZ_EN    = (LZ_SUPPRESS != 0);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_capture;
    logic        w_changed;

    logic [8:0]  r_last_src;
    logic [7:0]  r_work;
    logic [11:0] r_bcd;
    logic [11:0] w_bcd_adj;
    logic [2:0]  r_bit_cnt;

    logic [3:0]  r_d2, r_d1, r_d0;
    logic        r_blank2, r_blank1, r_blank0;

    logic [15:0] r_slot_cnt;
    logic [1:0]  r_digit_idx;
    logic [3:0]  r_nibble;
    logic        r_blank;
    logic [2:0]  r_digit_en;

    logic [3:0]  w_sel_nib;
    logic        w_sel_blank;
    logic [2:0]  w_onehot;

    // Mode is part of the source so a mode toggle alone forces recomputation.
    assign w_changed = ({bus.hex_mode, bus.sw} != r_last_src);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_changed) begin
                    w_capture = 1'b1;
                    w_next    = bus.hex_mode ? S_COMMIT : S_CONV;
                end
            end
            S_CONV: begin
                if (r_bit_cnt == 3'd7) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Double-dabble add-3 correction applied before each shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_src <= 9'd0;
            r_work     <= 8'd0;
            r_bcd      <= 12'd0;
            r_bit_cnt  <= 3'd0;
            r_d2       <= 4'd0;
            r_d1       <= 4'd0;
            r_d0       <= 4'd0;
            r_blank2   <= 1'b1;
            r_blank1   <= 1'b1;
            r_blank0   <= 1'b0;
        end else if (w_capture) begin
            r_last_src <= {bus.hex_mode, bus.sw};
            r_work     <= bus.sw;
            r_bcd      <= 12'd0;
            r_bit_cnt  <= 3'd0;
        end else if (r_state == S_CONV) begin
            {r_bcd, r_work} <= {w_bcd_adj[10:0], r_work, 1'b0};
            r_bit_cnt       <= r_bit_cnt + 3'd1;
        end else if (r_state == S_COMMIT) begin
            // The work register still holds the captured value in hex mode
            // because no shifting happens on that path.
            if (r_last_src[8]) begin
                r_d2     <= 4'd0;
                r_d1     <= r_work[7:4];
                r_d0     <= r_work[3:0];
                r_blank2 <= 1'b1;
                r_blank1 <= 1'b0;
            end else begin
                r_d2     <= r_bcd[11:8];
                r_d1     <= r_bcd[7:4];
                r_d0     <= r_bcd[3:0];
                r_blank2 <= LZ_EN && (r_bcd[11:8] == 4'd0);
                r_blank1 <= LZ_EN && (r_bcd[11:4] == 8'd0);
            end
            r_blank0 <= 1'b0;
        end
    end

    always_comb begin
        w_sel_nib   = r_d0;
        w_sel_blank = r_blank0;
        w_onehot    = 3'b001;
        case (r_digit_idx)
            2'd1: begin
                w_sel_nib   = r_d1;
                w_sel_blank = r_blank1;
                w_onehot    = 3'b010;
            end
            2'd2: begin
                w_sel_nib   = r_d2;
                w_sel_blank = r_blank2;
                w_onehot    = 3'b100;
            end
            default: begin
                w_sel_nib   = r_d0;
                w_sel_blank = r_blank0;
                w_onehot    = 3'b001;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_cnt  <= 16'd0;
            r_digit_idx <= 2'd0;
            r_nibble    <= 4'd0;
            r_blank     <= 1'b1;
            r_digit_en  <= 3'b000;
        end else begin
            if (r_slot_cnt == SLOT_MAX) begin
                r_slot_cnt  <= 16'd0;
                r_digit_idx <= (r_digit_idx == 2'd2) ? 2'd0 : r_digit_idx + 2'd1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 16'd1;
            end
            // Anti-ghosting gap: anodes off, nibble held so segments do not glitch.
            if (r_slot_cnt < BLANK_W) begin
                r_digit_en <= 3'b000;
                r_blank    <= 1'b1;
            end else begin
                r_digit_en <= w_onehot;
                r_nibble   <= w_sel_nib;
                r_blank    <= w_sel_blank;
            end
        end
    end

    assign bus.nibble   = r_nibble;
    assign bus.blank    = r_blank;
    assign bus.digit_en = r_digit_en;
    assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb/tb_sevenseg_scan_ctrl.sv - scoreboard bench for sevenseg_scan_ctrl
module tb_sevenseg_scan_ctrl;

    localparam int R_A = 4;
    localparam int B_A = 1;
    localparam int R_B = 7;
    localparam int B_B = 3;

    typedef struct packed {
        logic [11:0] dig;
        logic [2:0]  bl_lz;
        logic [2:0]  bl_nolz;
        logic [3:0]  blen;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw  = 8'd0;
    logic       hm  = 1'b0;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [8:0]  model_src = 9'd0;
    int unsigned k = 0;

    always #5 clk = ~clk;

    sevenseg_scan_ctrl_if if_a();
    sevenseg_scan_ctrl_if if_b();

    assign if_a.sw       = sw;
    assign if_a.hex_mode = hm;
    assign if_b.sw       = sw;
    assign if_b.hex_mode = hm;

    sevenseg_scan_ctrl #(.REFRESH_DIV(R_A), .BLANK_CYCLES(B_A), .LZ_SUPPRESS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    sevenseg_scan_ctrl #(.REFRESH_DIV(R_B), .BLANK_CYCLES(B_B), .LZ_SUPPRESS(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    logic [3:0] m_nib  [2];
    logic       m_blank[2];
    logic [2:0] m_en   [2];
    logic       m_busy [2];

    assign m_nib[0]   = if_a.nibble;
    assign m_blank[0] = if_a.blank;
    assign m_en[0]    = if_a.digit_en;
    assign m_busy[0]  = if_a.busy;
    assign m_nib[1]   = if_b.nibble;
    assign m_blank[1] = if_b.blank;
    assign m_en[1]    = if_b.digit_en;
    assign m_busy[1]  = if_b.busy;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal via integer division, hex via nibble split.
    function automatic exp_t model(input logic h, input logic [7:0] v);
        exp_t e;
        int hu, te, on;
        if (h) begin
            e.dig     = {4'd0, v[7:4], v[3:0]};
            e.bl_lz   = 3'b100;
            e.bl_nolz = 3'b100;
            e.blen    = 4'd1;
        end else begin
            hu        = int'(v) / 100;
            te        = (int'(v) / 10) % 10;
            on        = int'(v) % 10;
            e.dig     = {4'(hu), 4'(te), 4'(on)};
            e.bl_lz   = {hu == 0, (hu == 0) && (te == 0), 1'b0};
            e.bl_nolz = 3'b000;
            e.blen    = 4'd9;
        end
        return e;
    endfunction

    // Expected anode pattern after the kk-th clock edge since reset release.
    function automatic logic [2:0] scan_en(input int r, input int b, input int unsigned kk);
        int s, idx;
        s   = (int'(kk) - 1) % r;
        idx = ((int'(kk) - 1) / r) % 3;
        return (s >= b) ? 3'(1 << idx) : 3'b000;
    endfunction

    function automatic int scan_idx(input int r, input int unsigned kk);
        return ((int'(kk) - 1) / r) % 3;
    endfunction

    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    logic [11:0] cur_dig [2];
    logic [2:0]  cur_bl  [2];
    logic [11:0] pend_dig[2];
    logic [2:0]  pend_bl [2];
    logic        pend_v  [2];
    int          bcnt    [2];
    logic        bprev   [2];
    exp_t        last_pop;

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int r, b, idx;
            logic [2:0] een;
            r = (u == 0) ? R_A : R_B;
            b = (u == 0) ? B_A : B_B;
            if (k == 0) begin
                chk("rst_nibble", m_nib[u], 0);
                chk("rst_blank", m_blank[u], 1);
                chk("rst_digit_en", m_en[u], 0);
                chk("rst_busy", m_busy[u], 0);
                cur_dig[u] = 12'd0;
                cur_bl[u]  = 3'b110;
                pend_v[u]  = 1'b0;
                bcnt[u]    = 0;
                bprev[u]   = 1'b0;
            end else begin
                if (pend_v[u]) begin
                    cur_dig[u] = pend_dig[u];
                    cur_bl[u]  = pend_bl[u];
                    pend_v[u]  = 1'b0;
                end
                een = scan_en(r, b, k);
                chk($sformatf("digit_en_u%0d", u), m_en[u], een);
                if (een == 3'b000) begin
                    chk($sformatf("gap_blank_u%0d", u), m_blank[u], 1);
                end else begin
                    idx = scan_idx(r, k);
                    chk($sformatf("nibble_u%0d_d%0d", u, idx), m_nib[u], cur_dig[u][idx*4 +: 4]);
                    chk($sformatf("blank_u%0d_d%0d", u, idx), m_blank[u], cur_bl[u][idx]);
                end
                if (m_busy[u]) begin
                    bcnt[u]++;
                end else if (bprev[u]) begin
                    if (u == 0) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL commit_unexpected actual=commit required=none t=%0t", $time);
                        end else begin
                            last_pop = sb_q.pop_front();
                        end
                    end
                    chk($sformatf("busy_len_u%0d", u), bcnt[u], int'(last_pop.blen));
                    pend_dig[u] = last_pop.dig;
                    pend_bl[u]  = (u == 0) ? last_pop.bl_lz : last_pop.bl_nolz;
                    pend_v[u]   = 1'b1;
                    bcnt[u]     = 0;
                end
                bprev[u] = m_busy[u];
            end
        end
    end

    task automatic apply(input logic h, input logic [7:0] v);
        @(posedge clk); #1;
        sw = v;
        hm = h;
        if ({h, v} != model_src) begin
            sb_q.push_back(model(h, v));
            model_src = {h, v};
        end
    endtask

    task automatic settle(input int n);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0 && !if_a.busy && !if_b.busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("settle_done", done, 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam int SETTLE = 2 * 3 * R_B;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_src = 9'd0;
        settle(SETTLE);

        apply(1'b0, 8'd255);  settle(SETTLE);
        apply(1'b0, 8'd7);    settle(SETTLE);
        apply(1'b1, 8'hA5);   settle(SETTLE);
        apply(1'b0, 8'hA5);   settle(SETTLE);

        // Change arrives mid-conversion: both values are committed in order.
        apply(1'b0, 8'd100);
        repeat (3) @(posedge clk);
        apply(1'b0, 8'd199);
        settle(SETTLE);

        // Reset during a conversion aborts it; the stable input is reconverted.
        apply(1'b0, 8'd200);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        model_src = 9'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        if ({hm, sw} != model_src) begin
            sb_q.push_back(model(hm, sw));
            model_src = {hm, sw};
        end
        settle(SETTLE);

        for (int i = 0; i < 12; i++) begin
            apply(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            settle(SETTLE);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
